// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter_if
// Brief    : Fetch, MEM-stage and shared-bus signal bundle for mem_bus_arbiter.
// Revision : 1.0
// ============================================================================
interface mem_bus_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_ack;
  logic        flush;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;
  logic        stallreq_if;
  logic        stallreq_mem;

  // Arbiter side: serves the requesters and masters the bus.
  modport master (
    input  if_req, if_addr, flush, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
           bus_rdata, bus_ack,
    output if_data, if_ack, mem_rdata, mem_ack, bus_req, bus_we, bus_sel,
           bus_addr, bus_wdata, bus_err, stallreq_if, stallreq_mem
  );

  // Environment side: requesters and bus slave.
  modport slave (
    output if_req, if_addr, flush, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
           bus_rdata, bus_ack,
    input  if_data, if_ack, mem_rdata, mem_ack, bus_req, bus_we, bus_sel,
           bus_addr, bus_wdata, bus_err, stallreq_if, stallreq_mem
  );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : Single-port bus arbiter/sequencer for fetch and MEM stage, MEM first.
// Revision : 1.0
// ============================================================================
module mem_bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input wire clk,
  input wire rst,
  mem_bus_arbiter_if.master bif
);
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IF_ACC  = 2'd1,
    S_MEM_ACC = 2'd2
  } state_t;

  localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

  state_t      r_state;
  logic [7:0]  r_wcnt;
  logic        r_killed;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [3:0]  r_bus_sel;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic        r_bus_err;
  logic [31:0] r_if_data;
  logic        r_if_ack;
  logic [31:0] r_mem_rdata;
  logic        r_mem_ack;

  logic        w_ack_cycle;
  logic        w_if_kill;
  logic        w_expire;

  assign w_ack_cycle = r_if_ack | r_mem_ack;
  assign w_if_kill   = r_killed | bif.flush;
  assign w_expire    = ~bif.bus_ack & (r_wcnt == C_TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wcnt      <= 8'd0;
      r_killed    <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_sel   <= 4'd0;
      r_bus_addr  <= 32'd0;
      r_bus_wdata <= 32'd0;
      r_bus_err   <= 1'b0;
      r_if_data   <= 32'd0;
      r_if_ack    <= 1'b0;
      r_mem_rdata <= 32'd0;
      r_mem_ack   <= 1'b0;
    end else begin
      r_if_ack  <= 1'b0;
      r_mem_ack <= 1'b0;
      r_bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The requester still shows its old request during the ack cycle.
          if (!w_ack_cycle) begin
            if (bif.mem_req) begin
              r_state     <= S_MEM_ACC;
              r_bus_req   <= 1'b1;
              r_bus_we    <= bif.mem_we;
              r_bus_sel   <= bif.mem_sel;
              r_bus_addr  <= bif.mem_addr;
              r_bus_wdata <= bif.mem_wdata;
            end else if (bif.if_req && !bif.flush) begin
              r_state    <= S_IF_ACC;
              r_bus_req  <= 1'b1;
              r_bus_we   <= 1'b0;
              r_bus_sel  <= 4'b1111;
              r_bus_addr <= bif.if_addr;
            end
          end
        end
        S_IF_ACC, S_MEM_ACC: begin
          if (bif.bus_ack || w_expire) begin
            r_state   <= S_IDLE;
            r_bus_req <= 1'b0;
            r_wcnt    <= 8'd0;
            r_killed  <= 1'b0;
            r_bus_err <= w_expire;
            if (r_state == S_MEM_ACC) begin
              r_mem_ack <= 1'b1;
              if (w_expire) begin
                r_mem_rdata <= 32'd0;
              end else if (!r_bus_we) begin
                r_mem_rdata <= bif.bus_rdata;
              end
            end else if (!w_if_kill) begin
              r_if_ack  <= 1'b1;
              r_if_data <= w_expire ? 32'd0 : bif.bus_rdata;
            end
          end else begin
            r_wcnt <= r_wcnt + 8'd1;
            if (r_state == S_IF_ACC && bif.flush) begin
              r_killed <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bif.bus_req      = r_bus_req;
  assign bif.bus_we       = r_bus_we;
  assign bif.bus_sel      = r_bus_sel;
  assign bif.bus_addr     = r_bus_addr;
  assign bif.bus_wdata    = r_bus_wdata;
  assign bif.bus_err      = r_bus_err;
  assign bif.if_data      = r_if_data;
  assign bif.if_ack       = r_if_ack;
  assign bif.mem_rdata    = r_mem_rdata;
  assign bif.mem_ack      = r_mem_ack;
  assign bif.stallreq_mem = bif.mem_req & ~r_mem_ack;
  assign bif.stallreq_if  = bif.if_req & ~r_if_ack;
endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Brief    : Directed scenarios plus randomized traffic against a transaction model.
// Revision : 1.0
// ============================================================================
module tb_mem_bus_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bif();
  mem_bus_arbiter #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bif(bif));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  // Model: who owns the bus, how many cycles the request has been up, and
  // the expected registered outputs.
  int          m_owner = 0;  // 0 none, 1 fetch, 2 mem
  int          m_age   = 0;
  bit          m_killed = 1'b0;
  logic        e_bus_req = 0, e_bus_we = 0, e_bus_err = 0, e_if_ack = 0, e_mem_ack = 0;
  logic [3:0]  e_bus_sel = 0;
  logic [31:0] e_bus_addr = 0, e_bus_wdata = 0, e_if_data = 0, e_mem_rdata = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit prev_ack, done, expired, kill_now;
    logic [31:0] data;
    prev_ack = e_if_ack | e_mem_ack;
    if (rst) begin
      m_owner = 0; m_age = 0; m_killed = 0;
      e_bus_req = 0; e_bus_we = 0; e_bus_err = 0; e_if_ack = 0; e_mem_ack = 0;
      e_bus_sel = 0; e_bus_addr = 0; e_bus_wdata = 0; e_if_data = 0; e_mem_rdata = 0;
      return;
    end
    e_if_ack = 0; e_mem_ack = 0; e_bus_err = 0;
    if (m_owner == 0) begin
      if (!prev_ack && bif.mem_req) begin
        m_owner = 2; m_age = 0; m_killed = 0; e_bus_req = 1;
        e_bus_we = bif.mem_we; e_bus_sel = bif.mem_sel;
        e_bus_addr = bif.mem_addr; e_bus_wdata = bif.mem_wdata;
      end else if (!prev_ack && bif.if_req && !bif.flush) begin
        m_owner = 1; m_age = 0; m_killed = 0; e_bus_req = 1;
        e_bus_we = 0; e_bus_sel = 4'hF; e_bus_addr = bif.if_addr;
      end
    end else begin
      m_age++;
      kill_now = m_killed || (m_owner == 1 && bif.flush);
      done     = bif.bus_ack;
      expired  = !done && (m_age == TO + 1);
      if (done || expired) begin
        data = done ? bif.bus_rdata : 32'h0;
        e_bus_req = 0;
        e_bus_err = expired;
        if (m_owner == 2) begin
          e_mem_ack = 1;
          if (expired || !e_bus_we) e_mem_rdata = data;
        end else if (!kill_now) begin
          e_if_ack = 1;
          e_if_data = data;
        end
        m_owner = 0; m_killed = 0;
      end else begin
        m_killed = kill_now;
      end
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (chk_on) begin
      check("bus_req", 32'(bif.bus_req), 32'(e_bus_req));
      check("bus_we", 32'(bif.bus_we), 32'(e_bus_we));
      check("bus_sel", 32'(bif.bus_sel), 32'(e_bus_sel));
      check("bus_addr", bif.bus_addr, e_bus_addr);
      check("bus_wdata", bif.bus_wdata, e_bus_wdata);
      check("bus_err", 32'(bif.bus_err), 32'(e_bus_err));
      check("if_ack", 32'(bif.if_ack), 32'(e_if_ack));
      check("if_data", bif.if_data, e_if_data);
      check("mem_ack", 32'(bif.mem_ack), 32'(e_mem_ack));
      check("mem_rdata", bif.mem_rdata, e_mem_rdata);
      check("stallreq_if", 32'(bif.stallreq_if), 32'(bif.if_req & ~e_if_ack));
      check("stallreq_mem", 32'(bif.stallreq_mem), 32'(bif.mem_req & ~e_mem_ack));
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    bit silent = 0, seen_req = 0;
    int acks = 0;
    bif.if_req = 0; bif.if_addr = 0; bif.flush = 0;
    bif.mem_req = 0; bif.mem_we = 0; bif.mem_sel = 0; bif.mem_addr = 0; bif.mem_wdata = 0;
    bif.bus_rdata = 0; bif.bus_ack = 0;
    rst = 1;
    cyc(); cyc();
    chk_on = 1;
    check("reset_bus_req", 32'(bif.bus_req), 32'h0);
    check("reset_if_data", bif.if_data, 32'h0);
    rst = 0;
    cyc();

    // Zero-wait fetch.
    bif.if_req = 1; bif.if_addr = 32'h100;
    cyc();
    check("zw_bus_req_c1", 32'(bif.bus_req), 32'h1);
    check("zw_bus_addr", bif.bus_addr, 32'h100);
    check("zw_bus_sel", 32'(bif.bus_sel), 32'hF);
    bif.bus_ack = 1; bif.bus_rdata = 32'h3C010001;
    cyc();
    check("zw_if_ack_c2", 32'(bif.if_ack), 32'h1);
    check("zw_if_data", bif.if_data, 32'h3C010001);
    check("zw_model_if_data", e_if_data, 32'h3C010001);
    check("zw_stallreq_if", 32'(bif.stallreq_if), 32'h0);
    bif.if_req = 0; bif.bus_ack = 0;
    cyc();

    // Simultaneous requests: MEM first, fetch granted three cycles later.
    bif.if_req = 1; bif.if_addr = 32'h200;
    bif.mem_req = 1; bif.mem_we = 0; bif.mem_sel = 4'hF; bif.mem_addr = 32'h2000;
    cyc();
    check("sim_bus_addr_mem", bif.bus_addr, 32'h2000);
    bif.bus_ack = 1; bif.bus_rdata = 32'hDEADBEEF;
    cyc();
    check("sim_mem_ack", 32'(bif.mem_ack), 32'h1);
    check("sim_mem_rdata", bif.mem_rdata, 32'hDEADBEEF);
    check("sim_if_ack_low", 32'(bif.if_ack), 32'h0);
    bif.mem_req = 0; bif.bus_ack = 0;
    cyc();
    check("sim_no_grant_c3", 32'(bif.bus_req), 32'h0);
    cyc();
    check("sim_fetch_grant_c4", 32'(bif.bus_req), 32'h1);
    check("sim_fetch_addr", bif.bus_addr, 32'h200);
    bif.bus_ack = 1; bif.bus_rdata = 32'h24020005;
    cyc();
    check("sim_if_data", bif.if_data, 32'h24020005);
    bif.if_req = 0; bif.bus_ack = 0;
    cyc();

    // Store with three wait states.
    bif.mem_req = 1; bif.mem_we = 1; bif.mem_sel = 4'b0011;
    bif.mem_addr = 32'h3000; bif.mem_wdata = 32'h1234;
    cyc();
    for (int i = 1; i <= 4; i++) begin
      check("st_bus_req", 32'(bif.bus_req), 32'h1);
      check("st_bus_we", 32'(bif.bus_we), 32'h1);
      check("st_bus_sel", 32'(bif.bus_sel), 32'h3);
      check("st_bus_wdata", bif.bus_wdata, 32'h1234);
      check("st_bus_addr", bif.bus_addr, 32'h3000);
      acks += int'(bif.mem_ack);
      bif.bus_ack = (i == 4); bif.bus_rdata = 32'h55555555;
      cyc();
    end
    check("st_mem_ack", 32'(bif.mem_ack), 32'h1);
    check("st_mem_rdata_kept", bif.mem_rdata, 32'hDEADBEEF);
    acks += int'(bif.mem_ack);
    bif.mem_req = 0; bif.bus_ack = 0;
    cyc();
    acks += int'(bif.mem_ack);
    check("st_ack_count", 32'(acks), 32'h1);

    // Flush during a fetch with two wait states.
    bif.if_req = 1; bif.if_addr = 32'h300;
    cyc();
    bif.flush = 1;
    cyc();
    bif.flush = 0;
    check("fl_bus_req_wait2", 32'(bif.bus_req), 32'h1);
    cyc();
    bif.bus_ack = 1; bif.bus_rdata = 32'hAAAA5555;
    cyc();
    check("fl_bus_req_done", 32'(bif.bus_req), 32'h0);
    check("fl_if_ack", 32'(bif.if_ack), 32'h0);
    check("fl_if_data_kept", bif.if_data, 32'h24020005);
    bif.if_req = 0; bif.bus_ack = 0;
    cyc();

    // Timeout with a silent slave.
    bif.if_req = 1; bif.if_addr = 32'h400;
    cyc();
    for (int i = 1; i <= 5; i++) begin
      check("to_bus_req_high", 32'(bif.bus_req), 32'h1);
      check("to_bus_err_low", 32'(bif.bus_err), 32'h0);
      cyc();
    end
    check("to_bus_req_drop", 32'(bif.bus_req), 32'h0);
    check("to_bus_err", 32'(bif.bus_err), 32'h1);
    check("to_if_ack", 32'(bif.if_ack), 32'h1);
    check("to_if_data", bif.if_data, 32'h0);
    bif.if_req = 0;
    cyc();
    check("to_bus_err_pulse", 32'(bif.bus_err), 32'h0);

    // Reset in the middle of a MEM access.
    bif.mem_req = 1; bif.mem_we = 0; bif.mem_sel = 4'hF;
    bif.mem_addr = 32'h5000; bif.mem_wdata = 32'h77;
    cyc();
    check("rs_grant", 32'(bif.bus_req), 32'h1);
    cyc();
    rst = 1;
    cyc();
    check("rs_bus_req", 32'(bif.bus_req), 32'h0);
    check("rs_bus_addr", bif.bus_addr, 32'h0);
    check("rs_bus_wdata", bif.bus_wdata, 32'h0);
    check("rs_mem_rdata", bif.mem_rdata, 32'h0);
    check("rs_model_mem_rdata", e_mem_rdata, 32'h0);
    rst = 0;
    cyc();
    check("rs_regrant", 32'(bif.bus_req), 32'h1);
    check("rs_regrant_addr", bif.bus_addr, 32'h5000);
    bif.bus_ack = 1; bif.bus_rdata = 32'h600D;
    cyc();
    check("rs_mem_rdata_new", bif.mem_rdata, 32'h600D);
    bif.mem_req = 0; bif.bus_ack = 0;
    cyc();

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      bif.flush = ($urandom_range(0, 11) == 0);
      if (bif.bus_req && !seen_req) silent = ($urandom_range(0, 7) == 0);
      seen_req = bif.bus_req;
      bif.bus_ack = bif.bus_req && !silent && ($urandom_range(0, 2) == 0);
      bif.bus_rdata = $urandom;
      if (bif.mem_ack) bif.mem_req = 0;
      if (!bif.mem_req && $urandom_range(0, 3) == 0) begin
        bif.mem_req = 1; bif.mem_we = 1'($urandom);
        bif.mem_sel = 4'($urandom); bif.mem_addr = $urandom; bif.mem_wdata = $urandom;
      end
      if (bif.if_ack) bif.if_req = 0;
      if (!bif.if_req && $urandom_range(0, 2) == 0) begin
        bif.if_req = 1; bif.if_addr = $urandom;
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbiter and sequencer for the single-port memory bus that instruction fetch and the MEM stage share in the OpenMIPS core.
- Accepts one request from each side and runs one bus transaction at a time, MEM side first.
- Returns registered read data with a one-cycle ack pulse.
- Drives `stallreq_if` / `stallreq_mem` into the pipeline controller, which builds the `stall[5:0]` vector consumed by the pipeline registers.

## Interface
Parameters:
- `TIMEOUT`, default 255: wait-state limit per transaction. Range 1..255.

Ports:
- `clk`  in  1  system clock; everything updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high (`RstEnable` = 1'b1).
- `if_req`  in  1  fetch request. Held high until `if_ack`.
- `if_addr`  in  32  fetch word address.
- `if_data`  out  32  fetched instruction.
- `if_ack`  out  1  one-cycle fetch done pulse.
- `flush`  in  1  discard any pending or in-flight fetch.
- `mem_req`, `mem_we`  in  1  data request and write enable. Held until `mem_ack`.
- `mem_sel`  in  4  byte enables.
- `mem_addr`, `mem_wdata`  in  32  data address and write data.
- `mem_rdata`  out  32  load data.
- `mem_ack`  out  1  one-cycle data done pulse.
- `bus_req`, `bus_we`  out  1  bus request and write enable.
- `bus_sel`  out  4  bus byte enables.
- `bus_addr`, `bus_wdata`  out  32  bus address and write data.
- `bus_rdata`  in  32  bus read data.
- `bus_ack`  in  1  slave completion, valid only while `bus_req`=1.
- `bus_err`  out  1  one-cycle timeout pulse.
- `stallreq_if`, `stallreq_mem`  out  1  stall requests to the pipeline controller.

## Operation
FSM states: `IDLE`, `IF_ACC`, `MEM_ACC`. Wait counter `wcnt[7:0]`.

- Reset:
  - state `IDLE`, `wcnt`=0.
  - All outputs 0: `bus_*`, `if_data`, `mem_rdata`, both acks, `bus_err`.
- IDLE grant rule, evaluated only when `if_ack`=0 and `mem_ack`=0:
  - `mem_req`=1: go to `MEM_ACC`; register `mem_addr`/`mem_wdata`/`mem_sel`/`mem_we` onto `bus_*`; `bus_req`←1.
  - Else if `if_req`=1 and `flush`=0: go to `IF_ACC`; `bus_addr`←`if_addr`, `bus_we`←0, `bus_sel`←4'b1111, `bus_req`←1.
  - MEM wins simultaneous requests.
- ACC states:
  - `bus_*` hold stable; `wcnt` increments each cycle without `bus_ack`.
- Completion on `bus_ack`=1:
  - `bus_req`←0, `wcnt`←0, go to `IDLE`.
  - `MEM_ACC`: `mem_rdata`←`bus_rdata` (reads only; writes leave it unchanged), `mem_ack`←1.
  - `IF_ACC`: `if_data`←`bus_rdata`, `if_ack`←1, unless the fetch was flushed.
- Timeout: `wcnt`==`TIMEOUT` with no `bus_ack`:
  - Abort: `bus_req`←0, `bus_err`←1 for one cycle.
  - Requester gets its ack with data 32'h0.
- Flush:
  - `flush`=1 in any cycle of `IF_ACC` sets a `killed` flag.
  - The bus transaction still completes; on completion `if_ack` stays 0 and `if_data` is not updated.
  - `killed` clears on return to `IDLE`.
  - Flush has no effect on `MEM_ACC`.
- Stall requests (combinational from registered state):
  - `stallreq_mem` = `mem_req` & ~`mem_ack`
  - `stallreq_if` = `if_req` & ~`if_ack`
- Acks are the registered completion. The requester advances on the edge that ends the ack cycle, so no new grant is made in an ack cycle; this prevents re-serving the stale request.
- `rst` mid-transaction returns to reset state immediately. Any in-flight bus cycle is abandoned; the slave must tolerate `bus_req` dropping.

## Timing
- Grant: request seen in cycle n → `bus_req`=1 in n+1.
- `bus_ack` in cycle m → ack pulse and data valid in m+1, `bus_req`=0 in m+1.
- Zero-wait slave: request-to-ack latency 2 cycles; back-to-back period 3 cycles per transaction.
- `bus_*` never change while `bus_req`=1.
- At most one of `if_ack` / `mem_ack` / `bus_err` context is active per cycle.

## Test plan
- Zero-wait fetch: `if_req`=1, `if_addr`=0x100, slave acks immediately with 0x3C010001 → `bus_req` high in cycle 1; `if_ack`=1 and `if_data`=0x3C010001 in cycle 2; `stallreq_if` low in cycle 2.
- Simultaneous requests: `if_req` and `mem_req` (load 0x2000, slave data 0xDEADBEEF) → MEM served first, `mem_rdata`=0xDEADBEEF; fetch granted 3 cycles later.
- Store, 3 wait states: `mem_we`=1, `mem_sel`=4'b0011, `mem_wdata`=0x1234 → `bus_*` stable for 4 cycles; `mem_ack` once; `mem_rdata` unchanged.
- Flush during a fetch with 2 wait states: pulse `flush` in the first wait cycle → `bus_req` completes normally; `if_ack` never asserts; `if_data` keeps its old value.
- Timeout with `TIMEOUT`=4 and a silent slave: fetch → `bus_req` high for 5 cycles; then `bus_err`=1, `if_ack`=1, `if_data`=0.
- Reset mid-`MEM_ACC`: assert `rst` during a wait state → next cycle all outputs 0, state `IDLE`; a new request after reset is granted normally.
